// File: rtl/rob_param_if.sv
// Bundle of every non-clock/reset signal of the reorder buffer: dispatch, CDB,
// retire, recovery and status. The pipeline drives it as master, the ROB as slave.
interface rob_param_if #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 2,
  parameter int CDB_N = 2,
  parameter int TAG_W = 6
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [WIDTH-1:0]             dispatch_valid;
  logic [WIDTH-1:0][TAG_W-1:0]  dispatch_T_new;
  logic [WIDTH-1:0][TAG_W-1:0]  dispatch_T_old;
  logic [WIDTH-1:0]             dispatch_halt;
  logic                         dispatch_accept;
  logic [WIDTH-1:0][IW-1:0]     dispatch_idx;
  logic [CDB_N-1:0]             cdb_valid;
  logic [CDB_N-1:0][TAG_W-1:0]  cdb_tag;
  logic                         retire_en;
  logic [WIDTH-1:0]             retire_valid;
  logic [WIDTH-1:0][TAG_W-1:0]  retire_T_new;
  logic [WIDTH-1:0][TAG_W-1:0]  retire_T_old;
  logic [WIDTH-1:0]             retire_halt;
  logic                         squash_valid;
  logic [IW-1:0]                squash_idx;
  logic                         flush;
  logic [CW-1:0]                free_count;
  logic                         full;
  logic                         empty;
  logic                         halted;

  modport master (
    output dispatch_valid, dispatch_T_new, dispatch_T_old, dispatch_halt,
    output cdb_valid, cdb_tag, retire_en, squash_valid, squash_idx, flush,
    input  dispatch_accept, dispatch_idx, retire_valid, retire_T_new, retire_T_old,
    input  retire_halt, free_count, full, empty, halted
  );

  modport slave (
    input  dispatch_valid, dispatch_T_new, dispatch_T_old, dispatch_halt,
    input  cdb_valid, cdb_tag, retire_en, squash_valid, squash_idx, flush,
    output dispatch_accept, dispatch_idx, retire_valid, retire_T_new, retire_T_old,
    output retire_halt, free_count, full, empty, halted
  );
endinterface

// File: rtl/rob_param.sv
// Parameterised reorder buffer: multi-lane in-order dispatch and retire,
// CDB wakeup, branch squash, full flush and a sticky HALTED state.
module rob_param #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 2,
  parameter int CDB_N = 2,
  parameter int TAG_W = 6
) (
  input logic       clk_i,
  input logic       rst_ni,
  rob_param_if.slave rob
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic {RUN, HALTED} state_e;
  typedef logic [IW:0]   ptr_t;
  typedef logic [IW-1:0] idx_t;

  state_e                      state_q, state_d;
  ptr_t                        head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]            busy_q, busy_d, ready_q, ready_d;
  logic [DEPTH-1:0][TAG_W-1:0] tnew_q, told_q;
  logic [DEPTH-1:0]            halt_q;
  logic [CW-1:0]               free_q, free_d;
  logic                        full_q, empty_q;

  logic [CW-1:0]    k, n_ret;
  logic             accept, squash_hit, halt_ret;
  idx_t             sq_off;
  idx_t             disp_idx [WIDTH];
  idx_t             ret_idx  [WIDTH];
  logic [WIDTH-1:0] ret_valid;
  ptr_t             occ_d;

  assign squash_hit = rob.squash_valid && busy_q[rob.squash_idx];
  assign sq_off     = rob.squash_idx - head_q[IW-1:0];

  always_comb begin : dispatch_logic
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      k           = k + CW'(rob.dispatch_valid[i]);
      disp_idx[i] = tail_q[IW-1:0] + idx_t'(i);
    end
    // Compared against the registered free count, so slots freed by a
    // same-cycle retire are never handed out.
    accept = rst_ni && (k != '0) && (k <= free_q) && (state_q == RUN) &&
             !rob.squash_valid && !rob.flush;
  end

  always_comb begin : retire_logic
    logic go;
    // NOTE: always_comb uses blocking '=' and assigns every output a default
    // first, so the in-order chain below reads naturally and no latch appears.
    go        = rst_ni && rob.retire_en && (state_q == RUN) && !rob.flush;
    ret_valid = '0;
    n_ret     = '0;
    halt_ret  = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      ret_idx[j] = head_q[IW-1:0] + idx_t'(j);
      // A squash cuts the chain after the branch so no squashed entry commits.
      if (go && busy_q[ret_idx[j]] && ready_q[ret_idx[j]] &&
          (!squash_hit || idx_t'(j) <= sq_off)) begin
        ret_valid[j] = 1'b1;
        n_ret        = n_ret + CW'(1);
        if (halt_q[ret_idx[j]]) begin
          halt_ret = 1'b1;
          go       = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  always_comb begin : next_state
    idx_t off;
    busy_d  = busy_q;
    ready_d = ready_q;
    head_d  = head_q + ptr_t'(n_ret);
    tail_d  = tail_q;
    state_d = halt_ret ? HALTED : state_q;
    off     = '0;

    for (int e = 0; e < DEPTH; e++)
      for (int c = 0; c < CDB_N; c++)
        if (busy_q[e] && rob.cdb_valid[c] && tnew_q[e] == rob.cdb_tag[c])
          ready_d[e] = 1'b1;

    for (int j = 0; j < WIDTH; j++)
      if (ret_valid[j]) busy_d[ret_idx[j]] = 1'b0;

    if (rob.flush) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else if (squash_hit) begin
      for (int e = 0; e < DEPTH; e++) begin
        off = idx_t'(e) - head_q[IW-1:0];
        if (off > sq_off) busy_d[e] = 1'b0;
      end
      tail_d = head_q + ptr_t'(sq_off) + ptr_t'(1);
    end else if (accept) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (rob.dispatch_valid[i]) begin
          busy_d[disp_idx[i]]  = 1'b1;
          ready_d[disp_idx[i]] = 1'b0;
        end
      end
      tail_d = tail_q + ptr_t'(k);
    end

    occ_d  = tail_d - head_d;
    free_d = CW'(DEPTH) - occ_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      busy_q  <= '0;
      ready_q <= '0;
      free_q  <= CW'(DEPTH);
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      free_q  <= free_d;
      full_q  <= (free_d == '0);
      empty_q <= (free_d == CW'(DEPTH));
    end
  end

  // NOTE: payload fields are not reset; busy/ready gate every use of them,
  // which keeps the storage as plain enabled flops or RAM.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (rob.dispatch_valid[i]) begin
          tnew_q[disp_idx[i]] <= rob.dispatch_T_new[i];
          told_q[disp_idx[i]] <= rob.dispatch_T_old[i];
          halt_q[disp_idx[i]] <= rob.dispatch_halt[i];
        end
      end
    end
  end

  always_comb begin : outputs
    for (int i = 0; i < WIDTH; i++) begin
      rob.dispatch_idx[i] = disp_idx[i];
      rob.retire_T_new[i] = tnew_q[ret_idx[i]];
      rob.retire_T_old[i] = told_q[ret_idx[i]];
      rob.retire_halt[i]  = ret_valid[i] && halt_q[ret_idx[i]];
    end
  end

  assign rob.dispatch_accept = accept;
  assign rob.retire_valid    = ret_valid;
  assign rob.free_count      = free_q;
  assign rob.full            = full_q;
  assign rob.empty           = empty_q;
  assign rob.halted          = (state_q == HALTED);

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param (DEPTH=8, WIDTH=2, CDB_N=2): dispatched entries
// go into a scoreboard queue and are compared in order as they retire.
module tb_rob_param;
  localparam int DEPTH = 8;
  localparam int WIDTH = 2;
  localparam int CDB_N = 2;
  localparam int TAG_W = 6;

  typedef struct packed {
    logic [2:0]       idx;
    logic [TAG_W-1:0] tnew;
    logic [TAG_W-1:0] told;
    logic             halt;
  } rec_t;

  rec_t             sb[$];
  logic [TAG_W-1:0] tag_of [DEPTH];
  logic [TAG_W-1:0] next_tag;
  int               n_checks;
  int               n_errors;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_param_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CDB_N(CDB_N), .TAG_W(TAG_W)) rif ();

  rob_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CDB_N(CDB_N), .TAG_W(TAG_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rob    (rif)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rif.dispatch_valid = '0;
    rif.dispatch_T_new = '0;
    rif.dispatch_T_old = '0;
    rif.dispatch_halt  = '0;
    rif.cdb_valid      = '0;
    rif.cdb_tag        = '0;
    rif.retire_en      = 1'b1;
    rif.squash_valid   = 1'b0;
    rif.squash_idx     = '0;
    rif.flush          = 1'b0;
  endtask

  // Drives one dispatch cycle; on expected acceptance the lanes are pushed.
  task automatic dispatch(input logic [1:0] valid, input logic [1:0] halt,
                          input logic exp_acc, input logic [2:0] exp_idx0);
    logic [2:0] e;
    rec_t       r;
    for (int i = 0; i < WIDTH; i++) begin
      rif.dispatch_T_new[i] = next_tag;
      rif.dispatch_T_old[i] = next_tag ^ 6'h20;
      next_tag = next_tag + 6'd1;
    end
    rif.dispatch_valid = valid;
    rif.dispatch_halt  = halt;
    #1;
    check("dispatch_accept", rif.dispatch_accept, exp_acc);
    if (exp_acc) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (valid[i]) begin
          e = exp_idx0 + 3'(i);
          check("dispatch_idx", rif.dispatch_idx[i], e);
          r.idx  = e;
          r.tnew = rif.dispatch_T_new[i];
          r.told = rif.dispatch_T_old[i];
          r.halt = halt[i];
          sb.push_back(r);
          tag_of[e] = r.tnew;
        end
      end
    end
    tick();
    rif.dispatch_valid = '0;
    rif.dispatch_halt  = '0;
  endtask

  task automatic squash_model(input logic [2:0] s);
    int pos;
    pos = -1;
    foreach (sb[q]) if (sb[q].idx == s) pos = q;
    if (pos >= 0) while (sb.size() > pos + 1) void'(sb.pop_back());
  endtask

  // Retire monitor, sampled mid-cycle.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      for (int j = 0; j < WIDTH; j++) begin
        if (rif.retire_valid[j] === 1'b1) begin
          n_checks++;
          assert (sb.size() != 0) else begin
            n_errors++;
            $error("FAIL retire_unexpected: observed lane %0d retiring expected no entry", j);
          end
          if (sb.size() != 0) begin
            r = sb.pop_front();
            check("retire_T_new", rif.retire_T_new[j], r.tnew);
            check("retire_T_old", rif.retire_T_old[j], r.told);
            check("retire_halt", rif.retire_halt[j], r.halt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    next_tag = 6'd1;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_free", rif.free_count, 8);
    check("rst_empty", rif.empty, 1);
    check("rst_full", rif.full, 0);
    check("rst_halted", rif.halted, 0);
    check("rst_retire_valid", rif.retire_valid, 0);
    check("rst_accept", rif.dispatch_accept, 0);

    // Fill the buffer, then one rejected dispatch.
    for (int c = 0; c < 4; c++) dispatch(2'b11, 2'b00, 1'b1, 3'(2 * c));
    check("fill_free", rif.free_count, 0);
    check("fill_full", rif.full, 1);
    check("fill_empty", rif.empty, 0);
    dispatch(2'b11, 2'b00, 1'b0, 3'd0);
    check("full_free_hold", rif.free_count, 0);

    // Complete entry 1, then entry 0; both retire the cycle after.
    rif.cdb_valid  = 2'b01;
    rif.cdb_tag[0] = tag_of[1];
    tick();
    rif.cdb_tag[0] = tag_of[0];
    #1;
    check("retire_latency", rif.retire_valid, 2'b00);
    tick();
    rif.cdb_valid = '0;
    #1;
    check("retire_two", rif.retire_valid, 2'b11);
    tick();
    check("retire_free", rif.free_count, 2);
    check("retire_not_full", rif.full, 0);
    dispatch(2'b11, 2'b00, 1'b1, 3'd0);
    check("wrap_free", rif.free_count, 0);

    // Flush suppresses the retire of a ready head entry.
    rif.retire_en  = 1'b0;
    rif.cdb_valid  = 2'b01;
    rif.cdb_tag[0] = tag_of[2];
    tick();
    rif.cdb_valid = '0;
    rif.retire_en = 1'b1;
    rif.flush     = 1'b1;
    sb.delete();
    #1;
    check("flush_no_retire", rif.retire_valid, 2'b00);
    tick();
    rif.flush = 1'b0;
    check("flush_free", rif.free_count, 8);
    check("flush_empty", rif.empty, 1);
    check("flush_full", rif.full, 0);

    // Squash at entry 2 with six entries busy; same-cycle dispatch rejected.
    for (int c = 0; c < 3; c++) dispatch(2'b11, 2'b00, 1'b1, 3'(2 * c));
    check("six_free", rif.free_count, 2);
    rif.squash_valid = 1'b1;
    rif.squash_idx   = 3'd2;
    squash_model(3'd2);
    dispatch(2'b11, 2'b00, 1'b0, 3'd0);
    rif.squash_valid = 1'b0;
    check("squash_free", rif.free_count, 5);
    dispatch(2'b11, 2'b00, 1'b1, 3'd3);
    check("post_squash_free", rif.free_count, 3);

    // Complete everything and let the scoreboard drain it in order.
    rif.cdb_valid = 2'b11;
    rif.cdb_tag[0] = tag_of[0];
    rif.cdb_tag[1] = tag_of[1];
    tick();
    rif.cdb_tag[0] = tag_of[2];
    rif.cdb_tag[1] = tag_of[3];
    tick();
    rif.cdb_valid  = 2'b01;
    rif.cdb_tag[0] = tag_of[4];
    tick();
    rif.cdb_valid = '0;
    for (int n = 0; n < 20 && rif.empty !== 1'b1; n++) tick();
    check("drain_empty", rif.empty, 1);
    check("drain_free", rif.free_count, 8);
    check("drain_sb", sb.size(), 0);

    // Wrap across index 7 -> 0, then free_count=1 with a same-cycle retire.
    dispatch(2'b11, 2'b00, 1'b1, 3'd5);
    dispatch(2'b11, 2'b00, 1'b1, 3'd7);
    dispatch(2'b11, 2'b00, 1'b1, 3'd1);
    dispatch(2'b01, 2'b00, 1'b1, 3'd3);
    check("one_free", rif.free_count, 1);
    rif.cdb_valid  = 2'b01;
    rif.cdb_tag[0] = tag_of[5];
    tick();
    rif.cdb_valid = '0;
    check("single_retire", rif.retire_valid, 2'b01);
    dispatch(2'b11, 2'b00, 1'b0, 3'd0);
    check("freed_after_retire", rif.free_count, 2);
    dispatch(2'b11, 2'b00, 1'b1, 3'd4);
    check("refill_full", rif.full, 1);

    // Halt on lane 0 stops lane 1 and freezes the buffer.
    rif.flush = 1'b1;
    sb.delete();
    tick();
    rif.flush = 1'b0;
    dispatch(2'b11, 2'b01, 1'b1, 3'd0);
    rif.cdb_valid  = 2'b11;
    rif.cdb_tag[0] = tag_of[0];
    rif.cdb_tag[1] = tag_of[1];
    tick();
    rif.cdb_valid = '0;
    check("halt_retire_valid", rif.retire_valid, 2'b01);
    check("halt_retire_halt", rif.retire_halt, 2'b01);
    tick();
    check("halted", rif.halted, 1);
    check("halted_free", rif.free_count, 7);
    check("halted_no_retire", rif.retire_valid, 2'b00);
    dispatch(2'b11, 2'b00, 1'b0, 3'd0);

    // Reset leaves HALTED; reset also overrides a coincident squash.
    rst_n = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    check("reset_unhalt", rif.halted, 0);
    check("reset_free", rif.free_count, 8);
    dispatch(2'b11, 2'b00, 1'b1, 3'd0);
    dispatch(2'b01, 2'b00, 1'b1, 3'd2);
    check("three_free", rif.free_count, 5);
    rst_n = 1'b0;
    rif.squash_valid = 1'b1;
    rif.squash_idx   = 3'd1;
    sb.delete();
    tick();
    rst_n = 1'b1;
    rif.squash_valid = 1'b0;
    check("rst_squash_free", rif.free_count, 8);
    check("rst_squash_empty", rif.empty, 1);
    check("rst_squash_full", rif.full, 0);
    dispatch(2'b11, 2'b00, 1'b1, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rob_param.md
ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 Parameter DEPTH, default 32, ROB entries; power of two, at least 4.
REQ-002 Parameter WIDTH, default 2, dispatch and retire lanes per cycle; 1 to 4, WIDTH <= DEPTH.
REQ-003 Parameter CDB_N, default 2, completion broadcasts per cycle.
REQ-004 Parameter TAG_W, default 6, physical register index width.
REQ-005 Derived widths: IW = log2(DEPTH) for index ports; CW = IW+1 for count ports.
REQ-006 clock  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-low; entries cleared on the first rising clock edge with reset=0.
REQ-008 dispatch_valid  in  WIDTH  per-lane dispatch request; packed, so lane i valid implies lane i-1 valid.
REQ-009 dispatch_T_new, dispatch_T_old  in  WIDTH x TAG_W  new and previous physical tags per lane.
REQ-010 dispatch_halt  in  WIDTH  lane carries a halt instruction.
REQ-011 dispatch_accept  out  1  all valid lanes were written this cycle.
REQ-012 dispatch_idx  out  WIDTH x IW  ROB index assigned to each lane, valid when dispatch_accept=1.
REQ-013 cdb_valid  in  CDB_N  per-broadcast valid.
REQ-014 cdb_tag  in  CDB_N x TAG_W  completing physical tag per broadcast.
REQ-015 retire_en  in  1  commit stage can accept retirements this cycle.
REQ-016 retire_valid  out  WIDTH  lane retires this cycle; packed from lane 0.
REQ-017 retire_T_new, retire_T_old  out  WIDTH x TAG_W  tags of the retiring entries.
REQ-018 retire_halt  out  WIDTH  retiring entry is a halt.
REQ-019 squash_valid  in  1  branch mispredict recovery request.
REQ-020 squash_idx  in  IW  ROB index of the mispredicted branch.
REQ-021 flush  in  1  full pipeline flush.
REQ-022 free_count  out  CW  free entries, registered.
REQ-023 full, empty  out  1  registered; full=(free_count==0), empty=(free_count==DEPTH).
REQ-024 halted  out  1  high while in the HALTED state.

Function
REQ-025 Storage: circular buffer with head and tail pointers, each IW bits plus one wrap bit; occupancy = tail - head modulo 2*DEPTH.
REQ-026 Entry fields: busy, ready, T_new, T_old, halt.
REQ-027 Dispatch acceptance, all-or-nothing: accept when k = popcount(dispatch_valid) > 0, k <= registered free_count, state RUN, and no squash_valid or flush this cycle.
REQ-028 On accept, lane i writes entry (tail+i) mod DEPTH with busy=1, ready=0; tail advances by k; dispatch_idx[i] = (tail+i) mod DEPTH.
REQ-029 Dispatch never uses slots freed by a retire in the same cycle.
REQ-030 CDB: each busy entry whose T_new equals any valid cdb_tag sets ready=1 at the next edge.
REQ-031 CDB never marks an entry dispatched in the same cycle; duplicate matches are harmless.
REQ-032 Retire eligibility uses registered ready bits only; CDB-to-retire latency is at least 1 cycle.
REQ-033 Retire: when retire_en=1 and state RUN, lane j retires entry head+j iff entries head..head+j are all busy and ready. Retire is combinational from registered state.
REQ-034 After a retire, head advances by the count of retiring lanes and those entries clear busy.
REQ-035 Halt: a retiring entry with halt=1 is the last lane retired that cycle.
REQ-036 State machine RUN -> HALTED on the edge after a halt retires.
REQ-037 In HALTED: no dispatch, no retire, CDB updates still applied; leaves HALTED only on reset.
REQ-038 Squash, when squash_valid and entry squash_idx is busy: all entries younger than squash_idx clear busy; tail becomes squash_idx+1 with the wrap bit recomputed.
REQ-039 Squash does not block same-cycle retire of entries up to and including squash_idx.
REQ-040 squash_valid naming a non-busy entry is ignored.
REQ-041 Flush clears busy on all entries, sets head=tail=0 and free_count=DEPTH, and suppresses retire that cycle.
REQ-042 Priority when simultaneous: reset > flush > squash > dispatch.
REQ-043 free_count next value = DEPTH - next occupancy; wraps correctly across index DEPTH-1 -> 0.

Reset
REQ-044 While reset=0 at an edge: head=tail=0, all busy/ready=0, state RUN.
REQ-045 Outputs after reset: free_count=DEPTH, empty=1, full=0, halted=0; retire_valid=0 and dispatch_accept=0.
REQ-046 Reset asserted mid-operation discards all entries, including a pending squash; the first dispatch after reset receives index 0.

Verification (DEPTH=8, WIDTH=2, CDB_N=2)
REQ-047 Reset, dispatch 2 lanes for 4 cycles -> idx 0..7 assigned, full=1, free_count=0; a fifth 2-lane dispatch -> dispatch_accept=0.
REQ-048 From full, CDB tags of entries 1 then 0 -> retire lanes 0,1 one cycle after entry 0 ready; free_count=2; a next-cycle dispatch gets idx 0,1 (wrap).
REQ-049 6 entries busy, squash_idx=2 plus same-cycle 2-lane dispatch -> dispatch_accept=0; tail=3; entries 3-5 busy=0; free_count=5 if no retire occurs.
REQ-050 Entry 0 halt, entries 0,1 ready, retire_en=1 -> only lane 0 retires with retire_halt=1; halted=1 next cycle; later dispatches rejected.
REQ-051 free_count=1 and a 2-lane request with 1 entry retiring the same cycle -> reject; next cycle free_count=2 and the same request is accepted.
REQ-052 Dispatch 3 entries, then reset=0 for one cycle coincident with a squash -> free_count=8, empty=1, next dispatch idx 0.
